// File: rtl/softmax_pkg.sv
// Shared types, widths and helpers for the softmax normalisation sequencer.
package softmax_pkg;

  localparam int DATA_W = 8;                  // data word width (signed fixed point)
  localparam int FRAC_W = 4;                  // fractional bits, matches the divider
  localparam int DEPTH  = 16;                 // maximum row length
  localparam int SUM_W  = DATA_W + $clog2(DEPTH);
  localparam logic [DATA_W-1:0] POS_MAX = DATA_W'((1 << (DATA_W - 1)) - 1);

  typedef enum logic [2:0] {
    LOAD,
    PREP,
    ISSUE,
    WAIT,
    EMIT
  } norm_state_t;

  // Exponentiated scores should never be negative; clamp any that are to zero.
  function automatic logic [DATA_W-1:0] clamp_neg(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? '0 : x;
  endfunction

  // The divider takes a WIDTH-bit signed divisor, so the wide row sum is clipped.
  function automatic logic [DATA_W-1:0] sat_sum(input logic [SUM_W-1:0] s);
    return (s > SUM_W'(POS_MAX)) ? POS_MAX : s[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/softmax_norm_row_buf.sv
// Row buffer: register file with one synchronous write port and an asynchronous read.
module row_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Store one element per accepted input; contents need no reset since cnt gates use.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/softmax_norm.sv
// Softmax normalisation sequencer: buffers a row, sums it, then divides each
// element by the (saturated) sum through an external divider and streams results.
module softmax_norm
  import softmax_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int FBITS = FRAC_W,
  parameter int N     = DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic             div_busy,
  input  logic             div_done,
  input  logic             div_valid,
  input  logic             div_dbz,
  input  logic             div_ovf,
  input  logic [WIDTH-1:0] div_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_err
);

  localparam int AW    = $clog2(N);
  localparam int CNT_W = AW + 1;

  // The fixed-point format is only meaningful with at least one integer bit.
  if (FBITS >= WIDTH) begin : g_fbits_check
    $error("softmax_norm: FBITS must be smaller than WIDTH");
  end

  norm_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             sat_q, sat_d;
  logic             div_start_q, div_start_d;
  logic [WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] div_b_q, div_b_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_err_q, out_err_d;

  logic             buf_we;
  logic [WIDTH-1:0] buf_wdata;
  logic [WIDTH-1:0] buf_rdata;

  assign buf_wdata = clamp_neg(in_data);

  row_buf #(.WIDTH(WIDTH), .DEPTH(N), .AW(AW)) u_row_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (cnt_q[AW-1:0]),
    .wdata (buf_wdata),
    .raddr (idx_q),
    .rdata (buf_rdata)
  );

  // Next-state and datapath updates for the load / divide / emit sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    sat_d       = sat_q;
    div_start_d = 1'b0;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_err_d   = out_err_q;
    buf_we      = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          sum_d  = sum_q + SUM_W'(buf_wdata);
          // A full buffer closes the row even without in_last.
          if (in_last || (cnt_q == CNT_W'(N - 1))) begin
            state_d = PREP;
          end
        end
      end
      PREP: begin
        div_b_d = sat_sum(sum_q);
        if (sum_q > SUM_W'(POS_MAX)) begin
          sat_d = 1'b1;
        end
        idx_d   = '0;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (!div_busy) begin
          div_a_d     = buf_rdata;
          div_start_d = 1'b1;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (div_done) begin
          out_valid_d = 1'b1;
          out_last_d  = ({1'b0, idx_q} == (cnt_q - CNT_W'(1)));
          if (div_valid) begin
            out_data_d = div_val;
            out_err_d  = sat_q;
          end else if (div_dbz) begin
            out_data_d = '0;
            out_err_d  = 1'b1;
          end else if (div_ovf) begin
            out_data_d = POS_MAX;
            out_err_d  = 1'b1;
          end else begin
            // Done without any status bit: report as an error rather than trust div_val.
            out_data_d = '0;
            out_err_d  = 1'b1;
          end
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            cnt_d   = '0;
            sum_d   = '0;
            sat_d   = 1'b0;
            state_d = LOAD;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = ISSUE;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // State and output registers; reset aborts any row in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      sat_q       <= 1'b0;
      div_start_q <= 1'b0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      sat_q       <= sat_d;
      div_start_q <= div_start_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign div_start = div_start_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_softmax_norm.sv
// Scoreboard bench for softmax_norm with a behavioural fixed-point divider.
module tb_softmax_norm;

  localparam int W       = 8;
  localparam int DIV_LAT = 14;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         in_last = 1'b0;
  logic         div_start;
  logic [W-1:0] div_a, div_b;
  logic         div_busy = 1'b0, div_done = 1'b0, div_valid = 1'b0;
  logic         div_dbz = 1'b0, div_ovf = 1'b0;
  logic [W-1:0] div_val = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_last, out_err;

  softmax_norm dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_busy(div_busy), .div_done(div_done), .div_valid(div_valid),
    .div_dbz(div_dbz), .div_ovf(div_ovf), .div_val(div_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [W+1:0] sb[$];       // {data, last, err}
  int  vin[$];
  int  vexp[$];
  bit  bp_mode = 0;
  bit  pending_start = 0;
  bit  have_held = 0;
  logic [W+1:0] held;

  // Behavioural divider: q = (a << 4) / b, status pulses with done.
  initial begin
    int dcnt = 0;
    int qa, qb, q;
    forever begin
      @(posedge clk);
      div_done  <= 1'b0;
      div_valid <= 1'b0;
      div_dbz   <= 1'b0;
      div_ovf   <= 1'b0;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          div_done <= 1'b1;
          div_busy <= 1'b0;
          if (qb == 0) begin
            div_dbz <= 1'b1;
            div_val <= '0;
          end else begin
            q = (qa * 16) / qb;
            if (q > 127 || q < -128) begin
              div_ovf <= 1'b1;
              div_val <= '0;
            end else begin
              div_valid <= 1'b1;
              div_val   <= W'(q);
            end
          end
        end
      end else if (div_start) begin
        qa = int'($signed(div_a));
        qb = int'($signed(div_b));
        div_busy <= 1'b1;
        dcnt = DIV_LAT;
      end
    end
  end

  // Consumer ready: always 1, or 1-of-3 cycles in backpressure mode.
  initial begin
    int phase = 0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_mode ? (phase == 0) : 1'b1;
      phase = (phase == 2) ? 0 : phase + 1;
    end
  end

  // Monitor: compares outputs against the scoreboard, stall stability and start pacing.
  initial begin
    logic [W+1:0] got, exp_v;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (div_start) begin
          vectors++;
          if (pending_start) begin
            miscompares++;
            $display("FAIL start_pacing: got second div_start, required none before handshake");
          end
          pending_start = 1;
        end
        if (out_valid) begin
          got = {out_data, out_last, out_err};
          if (have_held) begin
            vectors++;
            if (got !== held) begin
              miscompares++;
              $display("FAIL stall_hold: got %h required %h", got, held);
            end
          end
          if (out_ready) begin
            vectors++;
            if (sb.size() == 0) begin
              miscompares++;
              $display("FAIL out_unexpected: got %h required no output", got);
            end else begin
              exp_v = sb.pop_front();
              if (got !== exp_v) begin
                miscompares++;
                $display("FAIL out_elem: got data=%0d last=%0b err=%0b required data=%0d last=%0b err=%0b",
                         got[W+1:2], got[1], got[0], exp_v[W+1:2], exp_v[1], exp_v[0]);
              end
            end
            pending_start = 0;
            have_held = 0;
          end else begin
            held = got;
            have_held = 1;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_div_start"}, int'(div_start), 0);
    chk({tag, "_outs"}, int'({out_data, out_last, out_err, div_a, div_b}), 0);
  endtask

  task automatic wait_ready();
    int t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 2000) begin
        $display("FAIL in_ready_timeout: got 0 required 1");
        $fatal(1, "in_ready never asserted");
      end
    end
  endtask

  // Drives vin[] as one row; pushes the hand-computed vexp[] results with err flag.
  task automatic send_row(input bit use_last, input bit err);
    int n = vin.size();
    for (int i = 0; i < n; i++) begin
      sb.push_back({W'(vexp[i]), (i == n - 1), err});
      in_valid = 1'b1;
      in_data  = W'(vin[i]);
      in_last  = use_last && (i == n - 1);
      wait_ready();
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("in_ready_fall", int'(in_ready), 0);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending required 0", sb.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk_reset_outputs("reset");
    @(posedge clk);
    #2;
    rst = 1'b0;

    vin = '{16, 16};          vexp = '{8, 8};          send_row(1, 0); wait_drain();
    vin = '{8, 24, 32};       vexp = '{2, 6, 8};       send_row(1, 0); wait_drain();
    vin = '{127, 127, 127, 127}; vexp = '{16, 16, 16, 16}; send_row(1, 1); wait_drain();
    vin = '{0, 0};            vexp = '{0, 0};          send_row(1, 1); wait_drain();
    vin = '{-16, 16};         vexp = '{0, 16};         send_row(1, 0); wait_drain();

    vin.delete();
    vexp.delete();
    for (int i = 0; i < 16; i++) begin
      vin.push_back(1);
      vexp.push_back(1);
    end
    send_row(0, 0);
    wait_drain();

    bp_mode = 1;
    vin = '{16, 16};          vexp = '{8, 8};          send_row(1, 0); wait_drain();
    bp_mode = 0;

    // Abort a row while the divider is working on its first element.
    vin = '{8, 24, 32};       vexp = '{2, 6, 8};       send_row(1, 0);
    begin
      int t = 0;
      while (!div_start && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk("start_seen", int'(div_start), 1);
    end
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    pending_start = 0;
    have_held = 0;
    #1;
    chk_reset_outputs("midrow_rst");
    @(posedge clk);
    #2;
    rst = 1'b0;
    vin = '{16, 16};          vexp = '{8, 8};          send_row(1, 0); wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout required completion");
    $fatal(1, "simulation timeout");
  end

endmodule

// File: doc/softmax_norm.md
# softmax_norm

Softmax normalisation sequencer for the attention path. Buffers one row of non-negative exponentiated scores, accumulates their sum, then drives the shared `divi` divider once per element (score / sum) and streams the normalised row out with valid/ready handshaking. It sits between the exponent stage and the attention-weight consumer and owns the divider's start/done handshake.

## Interface
- `WIDTH`, 8, word width of all data, signed fixed point; matches the divider.
- `FBITS`, 4, fractional bits; matches the divider.
- `N`, 16, maximum row length; buffer depth.
- `clk` in 1, the single clock.
- `rst` in 1, asynchronous, active-high reset.
- `in_valid` in 1, input element valid.
- `in_ready` out 1, high only in LOAD.
- `in_data` in WIDTH, signed score.
- `in_last` in 1, marks the last element of a row.
- `div_start` out 1, one-cycle start pulse to the divider.
- `div_a` out WIDTH, dividend, which is the buffered element.
- `div_b` out WIDTH, divisor, which is the saturated row sum.
- `div_busy`, `div_done`, `div_valid`, `div_dbz`, `div_ovf` in 1 each, divider status.
- `div_val` in WIDTH, divider quotient.
- `out_valid` out 1, output element valid.
- `out_ready` in 1, consumer ready.
- `out_data` out WIDTH, normalised element.
- `out_last` out 1, last element of a row.
- `out_err` out 1, element is not exact (see Operation).

## Operation
- **States:** LOAD, PREP, ISSUE, WAIT, EMIT.
- **Reset:** state is LOAD. Counters, sum and sum-saturation flag are 0. Every output is 0 except `in_ready`, which is 1.
- **LOAD:**
  - Each handshake (`in_valid & in_ready`) writes `max(in_data,0)` to `buf[cnt]`, adds the same value to `sum`, and increments `cnt`. Negative inputs clamp to 0.
  - `sum` is WIDTH+$clog2(N) bits wide.
  - An accepted `in_last`, or the acceptance of the N-th element, ends the row and moves to PREP. If the N-th element arrives without `in_last`, it is still treated as last.
- **PREP:**
  - `div_b` = `sum` if `sum` ≤ 2^(WIDTH-1)-1; otherwise `div_b` = 2^(WIDTH-1)-1 and the sticky `sat` flag is set.
  - Set `idx` = 0, then go to ISSUE.
- **ISSUE:**
  - Waits while `div_busy` = 1.
  - When `div_busy` = 0: drive `div_a` = `buf[idx]` and pulse `div_start` for exactly one cycle, then go to WAIT.
  - `div_a` and `div_b` are registered and stay stable until the next ISSUE.
- **WAIT:** on `div_done`, capture the result and go to EMIT.
  - If `div_valid`: `out_data` = `div_val`, `out_err` = `sat`.
  - If `div_dbz` (all-zero row): `out_data` = 0, `out_err` = 1.
  - If `div_ovf`: `out_data` = 2^(WIDTH-1)-1, `out_err` = 1.
- **EMIT:**
  - `out_valid` = 1; `out_data`, `out_last` and `out_err` are held until `out_ready`.
  - `out_last` = (`idx` == `cnt`-1).
  - On handshake: if last, clear `cnt`, `sum` and `sat`, then go to LOAD. Otherwise increment `idx` and go to ISSUE.
- A new row is never accepted before the previous row is fully emitted. There is no overlap.

## Timing
- `in_ready` falls in the cycle after the accepted last element.
- PREP lasts 1 cycle.
- `div_start` is asserted 1 cycle after entering ISSUE, provided the divider is idle.
- `out_valid` rises the cycle after `div_done`.
- Per-element latency is divider latency + 3 cycles with `out_ready` held at 1. With WIDTH=8 and FBITS=4, the divider takes about 14 cycles.
- `out_valid` deasserts the cycle after the output handshake.
- `div_done` arriving outside WAIT is ignored.
- `rst` mid-row aborts asynchronously:
  - buffered data is discarded;
  - `div_start` and `out_valid` drop immediately;
  - the block returns to LOAD.
- Any divider result still in flight after reset is ignored, because the block is not in WAIT.

## Structure
- Package `softmax_pkg`:
  - `norm_state_t` enum;
  - `SUM_W` = WIDTH+$clog2(N);
  - `POS_MAX` = 2^(WIDTH-1)-1;
  - clamp/saturate helper functions.
- Sub-module `row_buf`: N×WIDTH register file with one synchronous write port and one asynchronous read port, indexed by `cnt` and `idx`.
- The divider is instantiated by the parent, not inside this block.

## Test plan
All scenarios use WIDTH=8, FBITS=4, a real `divi` model, and `out_ready` held at 1 unless stated otherwise.
- **Two equal elements:** row 16, 16 (1.0, 1.0) → out 8, 8 (0.5). `out_last` only on the second element. `out_err` = 0.
- **Three elements:** row 8, 24, 32 → sum 64 → out 2, 6, 8. `out_err` = 0.
- **Sum saturation:** row 127×4 → sum 508 saturates to 127 → four outputs of 16, each with `out_err` = 1.
- **All-zero row:** row 0, 0 → divider reports `dbz` → out 0, 0 with `out_err` = 1.
- **Negative clamp and N limit:**
  - Row −16, 16 → out 0, 16.
  - Sixteen elements with `in_last` never asserted → row closes after the 16th element. `in_ready` = 0 during the next cycle.
- **Backpressure and reset:**
  - `out_ready` toggling 1-of-3 cycles → `out_data` stable while stalled, and no second `div_start` until the handshake.
  - `rst` pulsed during WAIT → all outputs return to reset values, and the next row is normalised correctly.
